// File: rtl/uart_rx_deframer.sv
// UART receive deframer: one sampled line bit per rx_clk edge, assembles LSB-first
// characters and presents them under a valid/ack handshake with error status.
module uart_rx_deframer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 rx_clk,
    input  logic                 rst,
    input  logic                 data_bit,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);

    state_t                state_reg, state_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic [1:0]            stop_cnt_reg, stop_cnt_next;
    logic                  perr_reg, perr_next;
    logic                  complete;
    logic                  frame_next;
    logic                  break_next;

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        perr_next     = perr_reg;
        complete      = 1'b0;
        frame_next    = 1'b0;
        break_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!data_bit) begin
                    state_next   = DATA;
                    bit_cnt_next = 4'd0;
                    perr_next    = 1'b0;
                end
            end
            DATA: begin
                shift_next   = {data_bit, shift_reg[DATA_BITS-1:1]};
                bit_cnt_next = bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == LAST_BIT) begin
                    stop_cnt_next = 2'd0;
                    state_next    = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                perr_next  = (^shift_reg) ^ data_bit ^ ODD;
                state_next = STOP;
            end
            STOP: begin
                if (data_bit) begin
                    if (stop_cnt_reg != LAST_STOP) begin
                        stop_cnt_next = stop_cnt_reg + 2'd1;
                    end else begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    // A low first stop bit after an all-zero character is a line break.
                    frame_next = 1'b1;
                    break_next = (stop_cnt_reg == 2'd0) && (shift_reg == '0);
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (data_bit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= 4'd0;
            stop_cnt_reg <= 2'd0;
            perr_reg     <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            perr_reg     <= perr_next;
            frame_err    <= frame_next;
            break_det    <= break_next;
            if (complete) begin
                // An unread, unacknowledged character wins; the new one is dropped.
                if (!rx_valid || rx_ack) begin
                    rx_data    <= shift_reg;
                    parity_err <= perr_reg;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_ack && rx_valid) begin
                rx_valid    <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: default framing instance plus an even-parity instance.
module tb_uart_rx_deframer;

    logic       rx_clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_bit = 1'b1;
    logic       rx_ack = 1'b0;
    logic       data_bit_p = 1'b1;
    logic       rx_ack_p = 1'b0;

    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, parity_err, frame_err, overrun_err, break_det, busy;
    logic       rx_valid_p, parity_err_p, frame_err_p, overrun_err_p, break_det_p, busy_p;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt, brk_cnt, val_cnt;

    uart_rx_deframer dut (
        .rx_clk(rx_clk), .rst(rst), .data_bit(data_bit), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun_err(overrun_err), .break_det(break_det), .busy(busy)
    );

    uart_rx_deframer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
        .rx_clk(rx_clk), .rst(rst), .data_bit(data_bit_p), .rx_ack(rx_ack_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .parity_err(parity_err_p),
        .frame_err(frame_err_p), .overrun_err(overrun_err_p), .break_det(break_det_p), .busy(busy_p)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c, input logic ack_first);
        data_bit = 1'b0;
        rx_ack   = ack_first;
        tick();
        rx_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_bit = c[i];
            tick();
        end
        data_bit = 1'b1;
        tick();
    endtask

    task automatic send_par(input logic [7:0] c, input logic pbit, input logic ack_first);
        data_bit_p = 1'b0;
        rx_ack_p   = ack_first;
        tick();
        rx_ack_p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_bit_p = c[i];
            tick();
        end
        data_bit_p = pbit;
        tick();
        data_bit_p = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},    32'(rx_data), 32'h0);
        chk({tag, "_valid"},   32'(rx_valid), 32'h0);
        chk({tag, "_perr"},    32'(parity_err), 32'h0);
        chk({tag, "_ferr"},    32'(frame_err), 32'h0);
        chk({tag, "_ovr"},     32'(overrun_err), 32'h0);
        chk({tag, "_brk"},     32'(break_det), 32'h0);
        chk({tag, "_busy"},    32'(busy), 32'h0);
    endtask

    initial begin
        // Reset held to 104 ns; outputs checked while asserted.
        #50;
        chk_all_zero("reset");
        #54;
        rst = 1'b0;
        tick();

        // 0x55 with default framing: line 0,1,0,1,0,1,0,1,0,1.
        send_char(8'h55, 1'b0);
        chk("c55_data",  32'(rx_data), 32'h55);
        chk("c55_valid", 32'(rx_valid), 32'h1);
        chk("c55_perr",  32'(parity_err), 32'h0);
        chk("c55_ferr",  32'(frame_err), 32'h0);
        chk("c55_busy",  32'(busy), 32'h0);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk("c55_ack_valid", 32'(rx_valid), 32'h0);

        // Back-to-back 0xA3 then 0x3C; ack of 0xA3 rides on 0x3C's start bit.
        send_char(8'hA3, 1'b0);
        chk("a3_data",  32'(rx_data), 32'hA3);
        chk("a3_valid", 32'(rx_valid), 32'h1);
        send_char(8'h3C, 1'b1);
        chk("3c_data",  32'(rx_data), 32'h3C);
        chk("3c_valid", 32'(rx_valid), 32'h1);
        chk("3c_ovr",   32'(overrun_err), 32'h0);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk("3c_ack_valid", 32'(rx_valid), 32'h0);

        // Overrun: 0x12 unread when 0x34 completes.
        send_char(8'h12, 1'b0);
        chk("12_data", 32'(rx_data), 32'h12);
        send_char(8'h34, 1'b0);
        chk("ovr_data",  32'(rx_data), 32'h12);
        chk("ovr_valid", 32'(rx_valid), 32'h1);
        chk("ovr_flag",  32'(overrun_err), 32'h1);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk("ovr_ack_valid", 32'(rx_valid), 32'h0);
        chk("ovr_ack_flag",  32'(overrun_err), 32'h0);

        // Break: line low for 12 bit times; stop sample is the 10th edge.
        fe_cnt = 0; brk_cnt = 0; val_cnt = 0;
        data_bit = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            fe_cnt  += int'(frame_err);
            brk_cnt += int'(break_det);
            val_cnt += int'(rx_valid);
            if (i == 9) begin
                chk("brk_ferr_at_stop", 32'(frame_err), 32'h1);
                chk("brk_det_at_stop",  32'(break_det), 32'h1);
            end
        end
        chk("brk_ferr_count",  32'(fe_cnt), 32'd1);
        chk("brk_det_count",   32'(brk_cnt), 32'd1);
        chk("brk_valid_count", 32'(val_cnt), 32'd0);
        chk("brk_busy_low_line", 32'(busy), 32'h1);
        data_bit = 1'b1;
        tick();
        chk("brk_busy_idle", 32'(busy), 32'h0);
        send_char(8'h7E, 1'b0);
        chk("7e_data",  32'(rx_data), 32'h7E);
        chk("7e_valid", 32'(rx_valid), 32'h1);
        chk("7e_ferr",  32'(frame_err), 32'h0);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;

        // Even parity on 0x07 (three ones): parity bit 1 is good, 0 is bad.
        send_par(8'h07, 1'b1, 1'b0);
        chk("par_good_data",  32'(rx_data_p), 32'h07);
        chk("par_good_valid", 32'(rx_valid_p), 32'h1);
        chk("par_good_perr",  32'(parity_err_p), 32'h0);
        send_par(8'h07, 1'b0, 1'b1);
        chk("par_bad_data",  32'(rx_data_p), 32'h07);
        chk("par_bad_valid", 32'(rx_valid_p), 32'h1);
        chk("par_bad_perr",  32'(parity_err_p), 32'h1);
        chk("par_bad_ferr",  32'(frame_err_p), 32'h0);

        // Mid-frame reset during the 4th data bit, with a character still held.
        send_char(8'h5A, 1'b0);
        chk("5a_valid", 32'(rx_valid), 32'h1);
        data_bit = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            data_bit = 1'b1;
            tick();
        end
        data_bit = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        tick();
        chk_all_zero("midrst_hold");
        rst = 1'b0;
        tick();
        send_char(8'hC5, 1'b0);
        chk("c5_data",  32'(rx_data), 32'hC5);
        chk("c5_valid", 32'(rx_valid), 32'h1);
        chk("c5_perr",  32'(parity_err), 32'h0);
        chk("c5_ovr",   32'(overrun_err), 32'h0);
        chk("c5_ferr",  32'(frame_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
